// File: rtl/msrv32_ifetch_buffer_if.sv
// ---------------------------------------------------------------------------
// msrv32_ifetch_buffer_if
// Bundles the signals of the instruction-fetch buffer that face the rest of
// the core:
//   - redirect:     flush_in, flush_pc_in
//   - AHB-Lite bus: haddr_out, htrans_out, hready_in, hrdata_in, hresp_in
//   - decode side:  valid_out, ready_in, instr_out, pc_out, fault_out
// The master modport is the fetch buffer's view. The slave modport is the
// view of its surroundings (bus slave, PC unit and decode together).
// ---------------------------------------------------------------------------
interface msrv32_ifetch_buffer_if;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hready_in;
  logic [31:0] hrdata_in;
  logic        hresp_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fault_out;

  modport master (
    input  flush_in, flush_pc_in, hready_in, hrdata_in, hresp_in, ready_in,
    output haddr_out, htrans_out, valid_out, instr_out, pc_out, fault_out
  );

  modport slave (
    output flush_in, flush_pc_in, hready_in, hrdata_in, hresp_in, ready_in,
    input  haddr_out, htrans_out, valid_out, instr_out, pc_out, fault_out
  );
endinterface

// File: rtl/msrv32_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// msrv32_ifetch_buffer
// This is the instruction-fetch stage that sits after the PC unit. It
// prefetches words in sequence over an AHB-Lite instruction port. Each
// result is stored in a small FIFO as {pc, instruction, fault}, and the head
// entry is offered to decode with a valid/ready handshake. A flush redirects
// fetch to a new target and discards every response that is still in flight.
//
// Ports:
//   clk_in    clock, rising edge
//   rst_n_in  synchronous active-low reset
//   bus       msrv32_ifetch_buffer_if.master. It carries the redirect, the
//             AHB signals and the decode handshake.
//
// Parameters: BOOT_ADDRESS is the fetch address after reset. DEPTH is the
// number of FIFO entries and must be a power of 2 from 2 to 8.
//
// Optional feature, enabled with the macro MSRV32_IFB_BYPASS_EN: while the
// FIFO is empty, a completing response is shown on the head outputs in the
// same cycle. If decode accepts it in that cycle, it is never written into
// the FIFO.
// ---------------------------------------------------------------------------
module msrv32_ifetch_buffer #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  msrv32_ifetch_buffer_if.master bus
);
  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = AW + 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [1:0]  HTRANS_IDLE = 2'b00;
  localparam logic [1:0]  HTRANS_NSEQ = 2'b10;

  typedef enum logic [0:0] {ADDR_FREE = 1'b0, ADDR_HELD = 1'b1} addr_state_e;

  addr_state_e   addr_state_q, addr_state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          dp_pending_q, dp_pending_d;
  logic [31:0]   dp_pc_q, dp_pc_d;
  logic          discard_q, discard_d;
  logic          hold_discard_q, hold_discard_d;
  logic          redirect_pend_q, redirect_pend_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   last_instr_q, last_instr_d, last_pc_q, last_pc_d;
  logic          last_fault_q, last_fault_d;
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic          fifo_fault_q [DEPTH];

  logic [31:0]   flush_target_s, resp_instr_s, head_pc_s, head_instr_s;
  logic [CW-1:0] occupancy_s, limit_s;
  logic          head_fault_s, fifo_nonempty_s, byp_s, valid_s, pop_s, fifo_pop_s;
  logic          push_s, issue_s, addr_active_s, accept_s, dp_done_s, resp_keep_s;

  // Bus, handshake and FIFO control decisions for the current cycle.
  always_comb begin
    flush_target_s  = bus.flush_pc_in & ~32'h0000_0003;
    dp_done_s       = dp_pending_q & bus.hready_in;
    resp_keep_s     = dp_done_s & ~discard_q & ~bus.flush_in;
    resp_instr_s    = bus.hresp_in ? NOP_INSTR : bus.hrdata_in;
    fifo_nonempty_s = (count_q != {(AW+1){1'b0}});
`ifdef MSRV32_IFB_BYPASS_EN
    byp_s           = resp_keep_s & ~fifo_nonempty_s;
`else
    byp_s           = 1'b0;
`endif
    valid_s         = fifo_nonempty_s | byp_s;
    pop_s           = valid_s & bus.ready_in;
    fifo_pop_s      = pop_s & fifo_nonempty_s;
    push_s          = resp_keep_s & ~(byp_s & bus.ready_in);
    // Compare count - pop + dp_pending < DEPTH with pop moved to the right,
    // so that the subtraction can never go negative.
    occupancy_s     = CW'(count_q) + CW'(dp_pending_q);
    limit_s         = CW'(DEPTH) + CW'(pop_s);
    issue_s         = ~bus.flush_in & (occupancy_s < limit_s);
    // A held address phase keeps driving NONSEQ whatever the issue rule says.
    addr_active_s   = rst_n_in & ((addr_state_q == ADDR_HELD) | issue_s);
    accept_s        = addr_active_s & bus.hready_in;

    if (fifo_nonempty_s) begin
      head_pc_s    = fifo_pc_q[rd_ptr_q];
      head_instr_s = fifo_instr_q[rd_ptr_q];
      head_fault_s = fifo_fault_q[rd_ptr_q];
    end else if (byp_s) begin
      head_pc_s    = dp_pc_q;
      head_instr_s = resp_instr_s;
      head_fault_s = bus.hresp_in;
    end else begin
      head_pc_s    = last_pc_q;
      head_instr_s = last_instr_q;
      head_fault_s = last_fault_q;
    end
  end

  // Address-phase FSM: an address phase is held until hready_in is seen high.
  always_comb begin
    addr_state_d = addr_state_q;
    case (addr_state_q)
      ADDR_FREE: begin
        if (addr_active_s && !bus.hready_in) begin
          addr_state_d = ADDR_HELD;
        end else begin
          addr_state_d = ADDR_FREE;
        end
      end
      ADDR_HELD: begin
        if (bus.hready_in) begin
          addr_state_d = ADDR_FREE;
        end else begin
          addr_state_d = ADDR_HELD;
        end
      end
      default: addr_state_d = ADDR_FREE;
    endcase
  end

  // Next state for the fetch pointer, the data phase, the discard flags and the FIFO bookkeeping.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    dp_pending_d    = dp_pending_q;
    dp_pc_d         = dp_pc_q;
    discard_d       = discard_q;
    hold_discard_d  = hold_discard_q;
    redirect_pend_d = redirect_pend_q;
    redirect_pc_d   = redirect_pc_q;

    if (accept_s) begin
      dp_pending_d    = 1'b1;
      dp_pc_d         = fetch_pc_q;
      // A held phase that a flush overtook still completes, but its data is stale.
      discard_d       = bus.flush_in | hold_discard_q;
      hold_discard_d  = 1'b0;
      redirect_pend_d = 1'b0;
      if (bus.flush_in) begin
        fetch_pc_d = flush_target_s;
      end else if (redirect_pend_q) begin
        fetch_pc_d = redirect_pc_q;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end else begin
      if (dp_done_s) begin
        dp_pending_d = 1'b0;
        discard_d    = 1'b0;
      end else if (bus.flush_in && dp_pending_q) begin
        discard_d = 1'b1;
      end else begin
        discard_d = discard_q;
      end
      if (bus.flush_in) begin
        if (addr_state_q == ADDR_HELD) begin
          // haddr_out must not move while the phase is held, so the target is parked.
          hold_discard_d  = 1'b1;
          redirect_pend_d = 1'b1;
          redirect_pc_d   = flush_target_s;
        end else begin
          fetch_pc_d = flush_target_s;
        end
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end

    if (bus.flush_in) begin
      count_d  = {(AW+1){1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
    end else begin
      count_d  = count_q + (AW+1)'(push_s) - (AW+1)'(fifo_pop_s);
      rd_ptr_d = rd_ptr_q + AW'(fifo_pop_s);
      wr_ptr_d = wr_ptr_q + AW'(push_s);
    end

    last_pc_d    = head_pc_s;
    last_instr_d = head_instr_s;
    last_fault_d = head_fault_s;
  end

  // State registers, with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_state_q    <= ADDR_FREE;
      fetch_pc_q      <= BOOT_ADDRESS;
      dp_pending_q    <= 1'b0;
      dp_pc_q         <= 32'h0000_0000;
      discard_q       <= 1'b0;
      hold_discard_q  <= 1'b0;
      redirect_pend_q <= 1'b0;
      redirect_pc_q   <= 32'h0000_0000;
      count_q         <= {(AW+1){1'b0}};
      rd_ptr_q        <= {AW{1'b0}};
      wr_ptr_q        <= {AW{1'b0}};
      last_instr_q    <= NOP_INSTR;
      last_pc_q       <= 32'h0000_0000;
      last_fault_q    <= 1'b0;
    end else begin
      addr_state_q    <= addr_state_d;
      fetch_pc_q      <= fetch_pc_d;
      dp_pending_q    <= dp_pending_d;
      dp_pc_q         <= dp_pc_d;
      discard_q       <= discard_d;
      hold_discard_q  <= hold_discard_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_pc_q   <= redirect_pc_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      last_instr_q    <= last_instr_d;
      last_pc_q       <= last_pc_d;
      last_fault_q    <= last_fault_d;
    end
  end

  // FIFO storage write port. The storage itself is not reset; count_q decides what is valid.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && push_s) begin
      fifo_pc_q[wr_ptr_q]    <= dp_pc_q;
      fifo_instr_q[wr_ptr_q] <= resp_instr_s;
      fifo_fault_q[wr_ptr_q] <= bus.hresp_in;
    end
  end

  assign bus.haddr_out  = fetch_pc_q;
  assign bus.htrans_out = addr_active_s ? HTRANS_NSEQ : HTRANS_IDLE;
  assign bus.valid_out  = valid_s;
  assign bus.instr_out  = head_instr_s;
  assign bus.pc_out     = head_pc_s;
  assign bus.fault_out  = head_fault_s;
endmodule

// File: tb/tb_msrv32_ifetch_buffer.sv
module tb_msrv32_ifetch_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic clk;
  logic rst_n;
  msrv32_ifetch_buffer_if bus();

  msrv32_ifetch_buffer #(.BOOT_ADDRESS(32'h0000_0000), .DEPTH(2)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  // bench-driven controls
  logic        drv_rst, drv_ready, drv_flush, err_en;
  logic [31:0] drv_flush_pc, err_addr;
  int          ws;
  // AHB slave model state
  logic        sl_valid, sl_stale;
  logic [31:0] sl_addr;
  int          sl_wait;
  // reference model state
  logic [31:0] exp_addr, pend_tgt;
  logic        pend, held_stale;
  logic        prev_held, cur_held, prev_stall;
  logic [31:0] prev_haddr;
  ent_t        prev_head;
  ent_t        sb[$];
  ent_t        pop_log[$];
  logic [31:0] iss_log[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] iss_at(input int i);
    return (i < iss_log.size()) ? iss_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic ent_t pop_at(input int i);
    ent_t e;
    e = '{pc: 32'hDEAD_BEEF, instr: 32'hDEAD_BEEF, fault: 1'b0};
    if (i < pop_log.size()) e = pop_log[i];
    return e;
  endfunction

  // One clock cycle: drive at negedge, model what the coming posedge does.
  task automatic step();
    logic do_pop, accepted, dp_done, new_stale;
    logic [31:0] tgt;
    ent_t e;
    @(negedge clk);
    rst_n           = drv_rst;
    bus.ready_in    = drv_ready;
    bus.flush_in    = drv_flush;
    bus.flush_pc_in = drv_flush_pc;
    bus.hready_in   = !(sl_valid && sl_wait != 0);
    bus.hrdata_in   = sl_valid ? mem_word(sl_addr) : 32'h0000_0000;
    bus.hresp_in    = sl_valid && err_en && (sl_addr == err_addr);
    #1;
    tgt = drv_flush_pc & ~32'h0000_0003;
    if (prev_held && drv_rst) begin
      check_val("hold_haddr", bus.haddr_out, prev_haddr);
      check_val("hold_htrans", 32'(bus.htrans_out), 32'h2);
    end
    if (prev_stall) begin
      check_val("stall_valid", 32'(bus.valid_out), 32'h1);
      check_val("stall_pc", bus.pc_out, prev_head.pc);
      check_val("stall_instr", bus.instr_out, prev_head.instr);
    end
    cur_held  = drv_rst && (bus.htrans_out == 2'b10) && !bus.hready_in;
    do_pop    = drv_rst && bus.valid_out && bus.ready_in;
    accepted  = drv_rst && (bus.htrans_out == 2'b10) && bus.hready_in;
    dp_done   = sl_valid && bus.hready_in;
    new_stale = 1'b0;
    if (drv_rst && (bus.htrans_out == 2'b10) && !prev_held) iss_log.push_back(bus.haddr_out);
    if (do_pop) begin
      check_val("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("pop_pc", bus.pc_out, e.pc);
        check_val("pop_instr", bus.instr_out, e.instr);
        check_val("pop_fault", 32'(bus.fault_out), 32'(e.fault));
      end
      pop_log.push_back('{pc: bus.pc_out, instr: bus.instr_out, fault: bus.fault_out});
    end
    if (!drv_rst) begin
      sb.delete();
      exp_addr   = 32'h0000_0000;
      pend       = 1'b0;
      held_stale = 1'b0;
      if (sl_valid && !dp_done) sl_stale = 1'b1;
    end else begin
      if (dp_done && !sl_stale && !drv_flush)
        sb.push_back('{pc: sl_addr, instr: bus.hresp_in ? 32'h0000_0013 : mem_word(sl_addr),
                       fault: bus.hresp_in});
      if (drv_flush) begin
        sb.delete();
        if (sl_valid && !dp_done) sl_stale = 1'b1;
      end
      if (accepted) begin
        check_val("acc_haddr", bus.haddr_out, exp_addr);
        new_stale  = held_stale | drv_flush;
        exp_addr   = drv_flush ? tgt : (pend ? pend_tgt : exp_addr + 32'd4);
        pend       = 1'b0;
        held_stale = 1'b0;
      end else if (drv_flush) begin
        if (bus.htrans_out == 2'b10) begin
          pend = 1'b1; pend_tgt = tgt; held_stale = 1'b1;
        end else begin
          exp_addr = tgt;
        end
      end
    end
    if (dp_done) sl_valid = 1'b0;
    else if (sl_valid && sl_wait > 0) sl_wait--;
    if (accepted) begin
      sl_valid = 1'b1; sl_addr = bus.haddr_out; sl_wait = ws; sl_stale = new_stale;
    end
    prev_held  = cur_held;
    prev_haddr = bus.haddr_out;
    prev_stall = drv_rst && bus.valid_out && !bus.ready_in && !drv_flush;
    prev_head  = '{pc: bus.pc_out, instr: bus.instr_out, fault: bus.fault_out};
  endtask

  task automatic do_reset();
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
    iss_log.delete();
    pop_log.delete();
  endtask

  initial begin
    int n0;
    ent_t e;
    drv_rst = 1'b0; drv_ready = 1'b1; drv_flush = 1'b0; drv_flush_pc = 32'h0;
    err_en = 1'b0; err_addr = 32'h0; ws = 0;
    sl_valid = 1'b0; sl_stale = 1'b0; sl_addr = 32'h0; sl_wait = 0;
    exp_addr = 32'h0; pend = 1'b0; pend_tgt = 32'h0; held_stale = 1'b0;
    prev_held = 1'b0; cur_held = 1'b0; prev_stall = 1'b0; prev_haddr = 32'h0;
    prev_head = '0;
    rst_n = 1'b0;
    bus.ready_in = 1'b1; bus.flush_in = 1'b0; bus.flush_pc_in = 32'h0;
    bus.hready_in = 1'b1; bus.hrdata_in = 32'h0; bus.hresp_in = 1'b0;

    // reset state
    step(); step();
    check_val("rst_htrans", 32'(bus.htrans_out), 32'h0);
    check_val("rst_haddr", bus.haddr_out, 32'h0000_0000);
    check_val("rst_valid", 32'(bus.valid_out), 32'h0);
    check_val("rst_instr", bus.instr_out, 32'h0000_0013);
    check_val("rst_pc", bus.pc_out, 32'h0);
    check_val("rst_fault", 32'(bus.fault_out), 32'h0);
    drv_rst = 1'b1;
    iss_log.delete(); pop_log.delete();

    // zero wait states, streaming
    repeat (6) step();
    for (int i = 0; i < 4; i++) check_val($sformatf("t1_addr%0d", i), iss_at(i), 32'(i * 4));
    n0 = pop_log.size();
    repeat (10) step();
    check_val("t1_rate", 32'(pop_log.size() - n0), 32'd10);
    check_val("t1_pop0", pop_at(0).pc, 32'h0);
    check_val("t1_pop1", pop_at(1).pc, 32'h4);

    // decode stalled for 10 cycles
    drv_ready = 1'b0;
    do_reset();
    repeat (10) step();
    check_val("t2_issued", 32'(iss_log.size()), 32'd2);
    check_val("t2_idle", 32'(bus.htrans_out), 32'h0);
    check_val("t2_valid", 32'(bus.valid_out), 32'h1);
    drv_ready = 1'b1;
    pop_log.delete();
    repeat (4) step();
    check_val("t2_pop0", pop_at(0).pc, 32'h0);
    check_val("t2_pop1", pop_at(1).pc, 32'h4);
    check_val("t2_pop2", pop_at(2).pc, 32'h8);

    // flush to 0x102 while a data phase waits
    ws = 2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (sl_valid && sl_wait != 0) break;
      step();
    end
    check_val("t3_dp_wait", 32'(sl_valid && sl_wait != 0), 32'h1);
    drv_flush = 1'b1; drv_flush_pc = 32'h0000_0102;
    step();
    drv_flush = 1'b0;
    iss_log.delete(); pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) step();
    check_val("t3_popped", 32'(pop_log.size() != 0), 32'h1);
    check_val("t3_addr", iss_at(0), 32'h0000_0100);
    check_val("t3_pc", pop_at(0).pc, 32'h0000_0100);

    // bus error on 0x8
    ws = 0; err_en = 1'b1; err_addr = 32'h8;
    do_reset();
    repeat (10) step();
    err_en = 1'b0;
    e = pop_at(2);
    check_val("t4_pc", e.pc, 32'h8);
    check_val("t4_fault", 32'(e.fault), 32'h1);
    check_val("t4_instr", e.instr, 32'h0000_0013);
    check_val("t4_next", iss_at(3), 32'hC);

    // flush while NONSEQ is held
    ws = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (cur_held) break;
    end
    check_val("t5_held", 32'(cur_held), 32'h1);
    drv_flush = 1'b1; drv_flush_pc = 32'h0000_0200;
    step();
    drv_flush = 1'b0; ws = 0;
    iss_log.delete(); pop_log.delete();
    for (int i = 0; i < 40 && pop_log.size() == 0; i++) step();
    check_val("t5_popped", 32'(pop_log.size() != 0), 32'h1);
    check_val("t5_addr", iss_at(0), 32'h0000_0200);
    check_val("t5_pc", pop_at(0).pc, 32'h0000_0200);

    // wrap at the top of the address space
    drv_flush = 1'b1; drv_flush_pc = 32'hFFFF_FFF8;
    iss_log.delete();
    step();
    drv_flush = 1'b0;
    repeat (8) step();
    check_val("t6_a0", iss_at(0), 32'hFFFF_FFF8);
    check_val("t6_a1", iss_at(1), 32'hFFFF_FFFC);
    check_val("t6_a2", iss_at(2), 32'h0000_0000);

    // reset in the middle of a data phase
    ws = 3;
    for (int i = 0; i < 10; i++) begin
      if (sl_valid && sl_wait != 0) break;
      step();
    end
    check_val("t7_dp_wait", 32'(sl_valid && sl_wait != 0), 32'h1);
    drv_rst = 1'b0;
    step(); step();
    check_val("t7_htrans", 32'(bus.htrans_out), 32'h0);
    check_val("t7_valid", 32'(bus.valid_out), 32'h0);
    drv_rst = 1'b1; ws = 0;
    iss_log.delete(); pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) step();
    check_val("t7_popped", 32'(pop_log.size() != 0), 32'h1);
    check_val("t7_pc", pop_at(0).pc, 32'h0);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/msrv32_ifetch_buffer.md
Name: msrv32_ifetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Takes the redirect target (pc_mux_out) on flush, runs sequential prefetch on an AHB-Lite instruction port, and buffers {pc, instruction, fault} in a small FIFO.
- Presents buffered entries to decode with a valid/ready handshake.
- Handles pipelined address/data phases, wait states, bus errors, and redirect flushes.

Parameters:
- BOOT_ADDRESS, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, FIFO entries; legal values 2..8, power of 2.

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- rst_n_in  input  1  synchronous reset, active-low
- flush_in  input  1  redirect request (branch/trap/mret)
- flush_pc_in  input  32  redirect target from PC unit; bits [1:0] ignored, treated as 00
- haddr_out  output  32  AHB address
- htrans_out  output  2  AHB transfer type; 2'b00 IDLE, 2'b10 NONSEQ only
- hready_in  input  1  AHB ready
- hrdata_in  input  32  AHB read data
- hresp_in  input  1  AHB error response
- valid_out  output  1  head entry valid
- ready_in  input  1  decode accepts head entry
- instr_out  output  32  head instruction
- pc_out  output  32  head instruction address
- fault_out  output  1  head entry carries a bus error

Behaviour:
- Reset (rst_n_in=0 at edge):
  - FIFO empty; fetch_pc=BOOT_ADDRESS.
  - No address phase pending; no data phase pending; discard flag clear.
  - Next cycle: htrans_out=IDLE, haddr_out=BOOT_ADDRESS, valid_out=0, instr_out=32'h0000_0013, pc_out=0, fault_out=0.
  - Reset mid-transaction abandons all bus state. No response is ever pushed after reset.
- Outputs:
  - haddr_out=fetch_pc.
  - htrans_out=NONSEQ while an address phase is active, else IDLE.
- Issue rule: a new address phase starts when all of the following hold:
  - no flush this cycle;
  - count - pop + dp_pending < DEPTH, where pop = valid_out & ready_in.
- Address-phase hold:
  - Once NONSEQ is driven with hready_in=0, haddr_out and htrans_out stay stable until a cycle with hready_in=1, even across flush.
- Address phase accepted (NONSEQ & hready_in=1):
  - dp_pending<=1, dp_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Data phase completes (dp_pending & hready_in=1):
  - If discard flag set: response dropped, discard cleared.
  - Else push {dp_pc, hrdata_in, hresp_in}.
  - An error entry stores instr=32'h0000_0013 and fault=1.
  - The next address phase may overlap, giving one word per cycle at zero wait states.
- Handshake:
  - valid_out = (count != 0).
  - Head fields are stable while valid_out=1 and ready_in=0.
  - Pop occurs on an edge with valid_out & ready_in.
  - When empty, instr_out/pc_out/fault_out hold their last values (reset values before any entry).
- Flush (flush_in=1 at edge):
  - FIFO cleared; fetch_pc<=flush_pc_in & ~3.
  - Any pending data phase, and any held address phase, marked discard.
  - No new address phase in the flush cycle.
  - valid_out=0 the following cycle.
  - Flush wins over a simultaneous pop and push.
  - Back-to-back flushes: the last target wins.
- Full: with count=DEPTH and no pop, htrans_out=IDLE. A pending data phase always has a slot reserved by the issue rule, so the FIFO never overflows.
- Simultaneous push and pop: count unchanged, order preserved.

Optional Feature:
- Macro MSRV32_IFB_BYPASS_EN.
- When defined:
  - If the FIFO is empty and a non-discarded data phase completes, valid_out=1 in the same cycle with hrdata_in, dp_pc and hresp_in on the head outputs.
  - If ready_in=1 that cycle, the entry is consumed without being written to the FIFO.
  - Fetch-to-decode latency: 1 cycle after address acceptance.
- When undefined: every entry is registered; latency 2 cycles after address acceptance.

Test Plan:
- Reset release, zero wait states, ready_in=1:
  - htrans NONSEQ at 0x0, 0x4, 0x8, ... on consecutive cycles.
  - valid_out entries in order (pc_out=0x0, 0x4, ...) with hrdata matching; one per cycle after fill.
- ready_in=0 for 10 cycles:
  - Exactly DEPTH=2 entries buffered, then htrans=IDLE.
  - On release, entries 0x0 and 0x4 delivered in order, no loss or duplicate.
- Flush to 0x0000_0102 while a data phase is pending with 2 wait states:
  - Stale response discarded.
  - Next NONSEQ haddr=0x0000_0100.
  - First valid pc_out=0x100.
- hresp_in=1 on the data phase for 0x8:
  - Entry pc_out=0x8, fault_out=1, instr_out=0x00000013.
  - Fetch continues at 0xC.
- Flush asserted while NONSEQ is held with hready_in=0:
  - haddr stable until accepted, response dropped.
  - Then fetch starts at the flush target.
- Flush to 0xFFFF_FFF8:
  - Addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted mid data phase:
  - Next cycle htrans=IDLE, valid_out=0.
  - The late response is not pushed.
